// File: rtl/scoreboard_forward_unit.sv
// Shift-register scoreboard of in-flight register writers.
// Issues load-use / long-latency stalls and registered bypass selects.
module scoreboard_forward_unit #(
  parameter int NREGS = 32,
  parameter int DEPTH = 3,
  parameter int NSRC  = 2,
  parameter int LAT_W = 2,
  localparam int RW = $clog2(NREGS),
  localparam int SW = $clog2(DEPTH + 2)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               adv,
  input  logic               flush,
  input  logic               iss_valid,
  input  logic               iss_wen,
  input  logic [RW-1:0]      iss_dest,
  input  logic [LAT_W-1:0]   iss_lat,
  input  logic [NSRC-1:0]    src_valid,
  input  logic [NSRC*RW-1:0] src_reg,
  output logic               stall,
  output logic [NSRC*SW-1:0] fwd_sel,
  output logic [NREGS-1:0]   busy
);

  logic [DEPTH:1]   slot_v;
  logic [RW-1:0]    slot_d [1:DEPTH];
  logic [LAT_W-1:0] slot_l [1:DEPTH];

  logic [RW-1:0]    src  [NSRC];
  logic [SW-1:0]    sel  [NSRC];
  logic [NSRC-1:0]  pend;
  logic             ins;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    assign src[g] = src_reg[g*RW +: RW];
  end

  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    pend = '0;
    for (int s = 0; s < NSRC; s++) begin
      sel[s] = '0;
      if (src_valid[s] && src[s] != '0) begin
        for (int k = DEPTH; k >= 1; k--) begin
          if (slot_v[k] && slot_d[k] == src[s]) begin
            sel[s]  = SW'(k + 1);
            pend[s] = (k < int'(slot_l[k]));
          end
        end
      end
    end
  end

  assign stall = (|pend) && iss_valid && !flush;
  assign ins   = iss_valid && iss_wen && !stall && !flush;

  always_comb begin
    busy = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (slot_v[k]) busy[slot_d[k]] = 1'b1;
    end
    busy[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      slot_v  <= '0;
      fwd_sel <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        slot_d[k] <= '0;
        slot_l[k] <= '0;
      end
    end else if (adv) begin
      slot_v[1] <= ins;
      slot_d[1] <= iss_dest;
      slot_l[1] <= iss_lat;
      // A resolved branch in EX squashes the instruction in slot 1.
      slot_v[2] <= slot_v[1] && !flush;
      slot_d[2] <= slot_d[1];
      slot_l[2] <= slot_l[1];
      for (int k = 3; k <= DEPTH; k++) begin
        slot_v[k] <= slot_v[k-1];
        slot_d[k] <= slot_d[k-1];
        slot_l[k] <= slot_l[k-1];
      end
      if (stall || flush || !iss_valid) begin
        fwd_sel <= '0;
      end else begin
        for (int s = 0; s < NSRC; s++) begin
          fwd_sel[s*SW +: SW] <= sel[s];
        end
      end
    end
  end

  a_lat_range: assert property (
    @(posedge CLK) disable iff (RST)
    (iss_valid && iss_wen && !flush) |-> (int'(iss_lat) <= DEPTH)
  );

endmodule
